ppu_vram_arbiter: RTL and testbench

Owns the PPU video bus (o_v_* / i_v_data) and shares it between two requesters: the background/sprite fetch engine (render port) and the CPU-side $2006/$2007 register path (CPU port). Holds the 14-bit VRAM address register, the $2006 write toggle and the $2007 read buffer. Sequences every external access as a fixed two-cycle bus cycle. Sits inside the PPU between the register decode and the external pins.

---
 rtl/ppu_vram_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arbiter.sv
// rtl/ppu_vram_arbiter.sv - PPU video bus arbiter with VRAM address register, $2006 toggle and $2007 buffer
module ppu_vram_arbiter (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rnd_req,
    input  logic [13:0] i_rnd_address,
    output logic        o_rnd_grant,
    output logic        o_rnd_valid,
    output logic [7:0]  o_rnd_data,
    input  logic        i_cpu_addr_write,
    input  logic        i_cpu_data_write,
    input  logic        i_cpu_data_read,
    input  logic [7:0]  i_cpu_data,
    input  logic        i_latch_clear,
    input  logic        i_inc32,
    output logic [7:0]  o_cpu_read_data,
    output logic        o_cpu_busy,
    output logic        o_v_rd_n,
    output logic        o_v_we_n,
    output logic [13:0] o_v_address,
    output logic [7:0]  o_v_data,
    input  logic [7:0]  i_v_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Bus cycle sequencer state
    logic [1:0]  state_q, state_d;
    logic        own_rnd_q, own_rnd_d;   // current bus cycle belongs to the render port
    logic        own_wr_q, own_wr_d;     // current bus cycle is a write

    // CPU register path state
    logic [13:0] vaddr_q, vaddr_d;
    logic        toggle_q, toggle_d;

    // Single CPU operation slot
    logic        pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;
    logic [13:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;

    // Registered outputs
    logic        v_rd_n_q, v_rd_n_d;
    logic        v_we_n_q, v_we_n_d;
    logic [13:0] v_address_q, v_address_d;
    logic [7:0]  v_data_q, v_data_d;
    logic        rnd_valid_q, rnd_valid_d;
    logic [7:0]  rnd_data_q, rnd_data_d;
    logic [7:0]  read_buf_q, read_buf_d;

    logic        cpu_busy;
    logic        accept_wr;
    logic        accept_rd;
    logic        arb;
    logic [13:0] inc;

    // The slot stays occupied until the CPU bus cycle finishes its DATA cycle
    assign cpu_busy = pend_q | ((state_q != ST_IDLE) & ~own_rnd_q);
    assign inc      = i_inc32 ? 14'd32 : 14'd1;

    // $2006/$2007 decode: address register, write toggle and slot admission
    always_comb begin
        vaddr_d   = vaddr_q;
        toggle_d  = toggle_q;
        accept_wr = 1'b0;
        accept_rd = 1'b0;
        if (i_cpu_addr_write) begin
            if (!toggle_q) begin
                vaddr_d[13:8] = i_cpu_data[5:0];
                toggle_d      = 1'b1;
            end else begin
                vaddr_d[7:0]  = i_cpu_data;
                toggle_d      = 1'b0;
            end
        end else if (i_cpu_data_write) begin
            if (!cpu_busy) begin
                accept_wr = 1'b1;
                vaddr_d   = vaddr_q + inc;
            end
        end else if (i_cpu_data_read) begin
            if (!cpu_busy) begin
                accept_rd = 1'b1;
                vaddr_d   = vaddr_q + inc;
            end
        end
        // Status read resets the toggle even when it coincides with a $2006 write
        if (i_latch_clear) begin
            toggle_d = 1'b0;
        end
    end

    // Bus sequencer: IDLE/ADDR/DATA with render-first arbitration in IDLE and DATA
    always_comb begin
        state_d     = state_q;
        own_rnd_d   = own_rnd_q;
        own_wr_d    = own_wr_q;
        pend_d      = pend_q;
        pend_wr_d   = pend_wr_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        v_rd_n_d    = 1'b1;
        v_we_n_d    = 1'b1;
        v_address_d = v_address_q;
        v_data_d    = v_data_q;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        read_buf_d  = read_buf_q;
        arb         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb = 1'b1;
            end
            ST_ADDR: begin
                // Strobes go low for exactly the DATA cycle that follows
                state_d  = ST_DATA;
                v_rd_n_d = own_wr_q;
                v_we_n_d = ~own_wr_q;
            end
            ST_DATA: begin
                if (!own_wr_q) begin
                    if (own_rnd_q) begin
                        rnd_valid_d = 1'b1;
                        rnd_data_d  = i_v_data;
                    end else begin
                        read_buf_d  = i_v_data;
                    end
                end
                arb = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arb) begin
            if (i_rnd_req) begin
                state_d     = ST_ADDR;
                own_rnd_d   = 1'b1;
                own_wr_d    = 1'b0;
                v_address_d = i_rnd_address;
            end else if (pend_q) begin
                state_d     = ST_ADDR;
                own_rnd_d   = 1'b0;
                own_wr_d    = pend_wr_q;
                v_address_d = pend_addr_q;
                if (pend_wr_q) begin
                    v_data_d = pend_data_q;
                end
                pend_d      = 1'b0;
            end else begin
                state_d     = ST_IDLE;
            end
        end

        // Admission only happens while the slot is empty, so it never races the grant above
        if (accept_wr) begin
            pend_d      = 1'b1;
            pend_wr_d   = 1'b1;
            pend_addr_d = vaddr_q;
            pend_data_d = i_cpu_data;
        end else if (accept_rd) begin
            pend_d      = 1'b1;
            pend_wr_d   = 1'b0;
            pend_addr_d = vaddr_q;
        end
    end

    // State registers with asynchronous reset so strobes release immediately
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            own_rnd_q   <= 1'b0;
            own_wr_q    <= 1'b0;
            vaddr_q     <= 14'd0;
            toggle_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= 14'd0;
            pend_data_q <= 8'd0;
            v_rd_n_q    <= 1'b1;
            v_we_n_q    <= 1'b1;
            v_address_q <= 14'd0;
            v_data_q    <= 8'd0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= 8'd0;
            read_buf_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            own_rnd_q   <= own_rnd_d;
            own_wr_q    <= own_wr_d;
            vaddr_q     <= vaddr_d;
            toggle_q    <= toggle_d;
            pend_q      <= pend_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            v_rd_n_q    <= v_rd_n_d;
            v_we_n_q    <= v_we_n_d;
            v_address_q <= v_address_d;
            v_data_q    <= v_data_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            read_buf_q  <= read_buf_d;
        end
    end

    assign o_rnd_grant     = (state_q == ST_ADDR) & own_rnd_q;
    assign o_rnd_valid     = rnd_valid_q;
    assign o_rnd_data      = rnd_data_q;
    assign o_cpu_read_data = read_buf_q;
    assign o_cpu_busy      = cpu_busy;
    assign o_v_rd_n        = v_rd_n_q;
    assign o_v_we_n        = v_we_n_q;
    assign o_v_address     = v_address_q;
    assign o_v_data        = v_data_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb/tb_ppu_vram_arbiter.sv - directed self-checking bench for ppu_vram_arbiter
module tb_ppu_vram_arbiter;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_rnd_req;
    logic [13:0] i_rnd_address;
    logic        o_rnd_grant;
    logic        o_rnd_valid;
    logic [7:0]  o_rnd_data;
    logic        i_cpu_addr_write;
    logic        i_cpu_data_write;
    logic        i_cpu_data_read;
    logic [7:0]  i_cpu_data;
    logic        i_latch_clear;
    logic        i_inc32;
    logic [7:0]  o_cpu_read_data;
    logic        o_cpu_busy;
    logic        o_v_rd_n;
    logic        o_v_we_n;
    logic [13:0] o_v_address;
    logic [7:0]  o_v_data;
    logic [7:0]  i_v_data;
    logic        use_model;
    logic [7:0]  v_fixed;

    int n_chk  = 0;
    int n_fail = 0;

    // VRAM stand-in: fixed byte, or a byte derived from the bus address
    assign i_v_data = use_model ? (o_v_address[7:0] ^ 8'hA5) : v_fixed;

    always #5 clk = ~clk;

    ppu_vram_arbiter dut (
        .i_clk            (clk),
        .i_reset_n        (i_reset_n),
        .i_rnd_req        (i_rnd_req),
        .i_rnd_address    (i_rnd_address),
        .o_rnd_grant      (o_rnd_grant),
        .o_rnd_valid      (o_rnd_valid),
        .o_rnd_data       (o_rnd_data),
        .i_cpu_addr_write (i_cpu_addr_write),
        .i_cpu_data_write (i_cpu_data_write),
        .i_cpu_data_read  (i_cpu_data_read),
        .i_cpu_data       (i_cpu_data),
        .i_latch_clear    (i_latch_clear),
        .i_inc32          (i_inc32),
        .o_cpu_read_data  (o_cpu_read_data),
        .o_cpu_busy       (o_cpu_busy),
        .o_v_rd_n         (o_v_rd_n),
        .o_v_we_n         (o_v_we_n),
        .o_v_address      (o_v_address),
        .o_v_data         (o_v_data),
        .i_v_data         (i_v_data)
    );

    task step;
        @(posedge clk);
        #1;
    endtask

    task samp;
        @(negedge clk);
    endtask

    task addr_wr(input logic [7:0] b);
        i_cpu_data = b; i_cpu_addr_write = 1'b1; step; i_cpu_addr_write = 1'b0;
    endtask

    task data_wr(input logic [7:0] b);
        i_cpu_data = b; i_cpu_data_write = 1'b1; step; i_cpu_data_write = 1'b0;
    endtask

    task data_rd;
        i_cpu_data_read = 1'b1; step; i_cpu_data_read = 1'b0;
    endtask

    task latch_clr;
        i_latch_clear = 1'b1; step; i_latch_clear = 1'b0;
    endtask

    task test_reset;
        i_reset_n = 1'b0;
        step; step;
        samp;
        n_chk++; if (o_v_rd_n !== 1'b1) begin n_fail++; $display("FAIL rst_rd_n: got %b expected 1", o_v_rd_n); end
        n_chk++; if (o_v_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b expected 1", o_v_we_n); end
        n_chk++; if (o_v_address !== 14'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", o_v_address); end
        n_chk++; if (o_v_data !== 8'h0) begin n_fail++; $display("FAIL rst_vdata: got %h expected 0", o_v_data); end
        n_chk++; if ({o_rnd_grant, o_rnd_valid, o_cpu_busy} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {o_rnd_grant, o_rnd_valid, o_cpu_busy}); end
        n_chk++; if ({o_rnd_data, o_cpu_read_data} !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0000", {o_rnd_data, o_cpu_read_data}); end
        step;
        i_reset_n = 1'b1;
        step;
    endtask

    task test_cpu_write;
        addr_wr(8'h21); addr_wr(8'h08); data_wr(8'h5A);
        samp;
        n_chk++; if (o_cpu_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_pend: got %b expected 1", o_cpu_busy); end
        step; samp;
        n_chk++; if (o_v_address !== 14'h2108) begin n_fail++; $display("FAIL wr_addr: got %h expected 2108", o_v_address); end
        n_chk++; if (o_v_data !== 8'h5A) begin n_fail++; $display("FAIL wr_vdata: got %h expected 5a", o_v_data); end
        n_chk++; if ({o_v_we_n, o_v_rd_n, o_rnd_grant} !== 3'b110) begin n_fail++; $display("FAIL wr_addr_strobes: got %b expected 110", {o_v_we_n, o_v_rd_n, o_rnd_grant}); end
        step; samp;
        n_chk++; if ({o_v_we_n, o_v_rd_n} !== 2'b01) begin n_fail++; $display("FAIL wr_data_strobes: got %b expected 01", {o_v_we_n, o_v_rd_n}); end
        n_chk++; if ({o_v_address, o_v_data} !== 22'h21085A) begin n_fail++; $display("FAIL wr_data_hold: got %h expected 21085a", {o_v_address, o_v_data}); end
        n_chk++; if (o_cpu_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_data: got %b expected 1", o_cpu_busy); end
        step; samp;
        n_chk++; if ({o_v_we_n, o_cpu_busy} !== 2'b10) begin n_fail++; $display("FAIL wr_done: got %b expected 10", {o_v_we_n, o_cpu_busy}); end
        data_wr(8'h33);
        step; samp;
        n_chk++; if (o_v_address !== 14'h2109) begin n_fail++; $display("FAIL wr_incr: got %h expected 2109", o_v_address); end
        step; step;
    endtask

    task test_cpu_read_inc32;
        i_inc32 = 1'b1; v_fixed = 8'h77;
        addr_wr(8'h3F); addr_wr(8'hF0); data_rd;
        step; samp;
        n_chk++; if (o_v_address !== 14'h3FF0) begin n_fail++; $display("FAIL rd_addr: got %h expected 3ff0", o_v_address); end
        step; samp;
        n_chk++; if ({o_v_rd_n, o_v_we_n} !== 2'b01) begin n_fail++; $display("FAIL rd_strobes: got %b expected 01", {o_v_rd_n, o_v_we_n}); end
        n_chk++; if (o_cpu_read_data !== 8'h00) begin n_fail++; $display("FAIL rd_first: got %h expected 00", o_cpu_read_data); end
        step; samp;
        n_chk++; if ({o_cpu_busy, o_v_rd_n} !== 2'b01) begin n_fail++; $display("FAIL rd_done: got %b expected 01", {o_cpu_busy, o_v_rd_n}); end
        v_fixed = 8'h12;
        data_rd;
        step; samp;
        n_chk++; if (o_v_address !== 14'h0010) begin n_fail++; $display("FAIL rd_wrap32: got %h expected 0010", o_v_address); end
        n_chk++; if (o_cpu_read_data !== 8'h77) begin n_fail++; $display("FAIL rd_second: got %h expected 77", o_cpu_read_data); end
        step; step; samp;
        n_chk++; if (o_cpu_read_data !== 8'h12) begin n_fail++; $display("FAIL rd_buf_upd: got %h expected 12", o_cpu_read_data); end
        i_inc32 = 1'b0;
        step;
    endtask

    task test_back_to_back;
        int pulses;
        pulses = 0;
        use_model = 1'b1;
        i_rnd_req = 1'b1; i_rnd_address = 14'h0000;
        step;
        for (int i = 0; i < 3; i++) begin
            samp;
            n_chk++; if ({o_rnd_grant, o_v_rd_n} !== 2'b11) begin n_fail++; $display("FAIL b2b_grant%0d: got %b expected 11", i, {o_rnd_grant, o_v_rd_n}); end
            n_chk++; if (o_v_address !== 14'(i)) begin n_fail++; $display("FAIL b2b_addr%0d: got %h expected %h", i, o_v_address, 14'(i)); end
            if (o_rnd_valid === 1'b1) pulses++;
            if (i > 0) begin
                n_chk++; if (o_rnd_data !== (8'(i - 1) ^ 8'hA5)) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", i, o_rnd_data, 8'(i - 1) ^ 8'hA5); end
            end
            step;
            if (i < 2) i_rnd_address = 14'(i + 1);
            else i_rnd_req = 1'b0;
            samp;
            n_chk++; if ({o_v_rd_n, o_rnd_grant, o_v_we_n} !== 3'b001) begin n_fail++; $display("FAIL b2b_data_cyc%0d: got %b expected 001", i, {o_v_rd_n, o_rnd_grant, o_v_we_n}); end
            step;
        end
        samp;
        if (o_rnd_valid === 1'b1) pulses++;
        n_chk++; if (o_rnd_data !== 8'hA7) begin n_fail++; $display("FAIL b2b_last_data: got %h expected a7", o_rnd_data); end
        n_chk++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
        step; samp;
        n_chk++; if ({o_rnd_valid, o_v_rd_n} !== 2'b01) begin n_fail++; $display("FAIL b2b_idle: got %b expected 01", {o_rnd_valid, o_v_rd_n}); end
        use_model = 1'b0;
    endtask

    task test_render_priority;
        use_model = 1'b1;
        addr_wr(8'h05); addr_wr(8'h00); data_wr(8'hC3);
        i_rnd_req = 1'b1; i_rnd_address = 14'h0100;
        step; samp;
        n_chk++; if ({o_rnd_grant, o_cpu_busy} !== 2'b11) begin n_fail++; $display("FAIL pri_grant: got %b expected 11", {o_rnd_grant, o_cpu_busy}); end
        n_chk++; if (o_v_address !== 14'h0100) begin n_fail++; $display("FAIL pri_rnd_addr: got %h expected 0100", o_v_address); end
        step;
        i_rnd_req = 1'b0;
        samp;
        n_chk++; if ({o_v_rd_n, o_cpu_busy} !== 2'b01) begin n_fail++; $display("FAIL pri_rnd_data: got %b expected 01", {o_v_rd_n, o_cpu_busy}); end
        step; samp;
        n_chk++; if ({o_v_address, o_v_data} !== 22'h0500C3) begin n_fail++; $display("FAIL pri_cpu_addr: got %h expected 0500c3", {o_v_address, o_v_data}); end
        n_chk++; if ({o_rnd_grant, o_rnd_valid, o_cpu_busy} !== 3'b011) begin n_fail++; $display("FAIL pri_cpu_flags: got %b expected 011", {o_rnd_grant, o_rnd_valid, o_cpu_busy}); end
        n_chk++; if (o_rnd_data !== 8'hA5) begin n_fail++; $display("FAIL pri_rnd_byte: got %h expected a5", o_rnd_data); end
        step; samp;
        n_chk++; if ({o_v_we_n, o_cpu_busy} !== 2'b01) begin n_fail++; $display("FAIL pri_cpu_we: got %b expected 01", {o_v_we_n, o_cpu_busy}); end
        step; samp;
        n_chk++; if ({o_v_we_n, o_cpu_busy} !== 2'b10) begin n_fail++; $display("FAIL pri_done: got %b expected 10", {o_v_we_n, o_cpu_busy}); end
        use_model = 1'b0;
    endtask

    task test_ignore_and_latch;
        addr_wr(8'h12); latch_clr; addr_wr(8'h34); addr_wr(8'h56);
        data_wr(8'h11); data_wr(8'h22);
        samp;
        n_chk++; if ({o_v_address, o_v_data} !== 22'h345611) begin n_fail++; $display("FAIL ign_first: got %h expected 345611", {o_v_address, o_v_data}); end
        step; samp;
        n_chk++; if ({o_v_we_n, o_v_data} !== 9'h011) begin n_fail++; $display("FAIL ign_data: got %h expected 011", {o_v_we_n, o_v_data}); end
        step; samp;
        n_chk++; if (o_cpu_busy !== 1'b0) begin n_fail++; $display("FAIL ign_dropped: got %b expected 0", o_cpu_busy); end
        data_wr(8'h33);
        step; samp;
        n_chk++; if ({o_v_address, o_v_data} !== 22'h345733) begin n_fail++; $display("FAIL ign_incr_once: got %h expected 345733", {o_v_address, o_v_data}); end
        step; step;
    endtask

    task test_reset_mid_cycle;
        data_wr(8'h44);
        step; step; samp;
        n_chk++; if (o_v_we_n !== 1'b0) begin n_fail++; $display("FAIL mid_pre_we: got %b expected 0", o_v_we_n); end
        #2 i_reset_n = 1'b0;
        #1;
        n_chk++; if ({o_v_we_n, o_v_rd_n, o_cpu_busy, o_rnd_grant, o_rnd_valid} !== 5'b11000) begin n_fail++; $display("FAIL mid_flags: got %b expected 11000", {o_v_we_n, o_v_rd_n, o_cpu_busy, o_rnd_grant, o_rnd_valid}); end
        n_chk++; if ({o_v_address, o_v_data, o_cpu_read_data, o_rnd_data} !== 38'h0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", {o_v_address, o_v_data, o_cpu_read_data, o_rnd_data}); end
        step;
        i_reset_n = 1'b1;
        step; step; samp;
        n_chk++; if ({o_v_we_n, o_cpu_busy} !== 2'b10) begin n_fail++; $display("FAIL mid_discard: got %b expected 10", {o_v_we_n, o_cpu_busy}); end
        data_rd;
        step; samp;
        n_chk++; if (o_v_address !== 14'h0000) begin n_fail++; $display("FAIL mid_vaddr_rst: got %h expected 0000", o_v_address); end
        step; step;
    endtask

    initial begin
        i_reset_n = 1'b0; i_rnd_req = 1'b0; i_rnd_address = 14'h0;
        i_cpu_addr_write = 1'b0; i_cpu_data_write = 1'b0; i_cpu_data_read = 1'b0;
        i_cpu_data = 8'h0; i_latch_clear = 1'b0; i_inc32 = 1'b0;
        use_model = 1'b0; v_fixed = 8'h00;
        test_reset;
        test_cpu_write;
        test_cpu_read_inc32;
        test_back_to_back;
        test_render_priority;
        test_ignore_and_latch;
        test_reset_mid_cycle;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
